// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V datapath.
// The FSM and the datapath muxes both use these constants, so a
// select value always means the same thing on both sides.
package riscv_ctrl_pkg;

    // FSM state encodings
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Memory address mux
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Full set of datapath controls driven every cycle
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // beq takes the branch on equal (zero), bne on not-equal
    function automatic logic branch_taken(input logic zero, input logic is_bne);
        return zero ^ is_bne;
    endfunction

endpackage

// File: rtl/ctrl_out_decoder.sv
// Combinational state -> control-output table for the multicycle FSM.
// Only the FETCH enables and the BRANCH PC enable look at live inputs;
// everything else is a pure function of the current state.
module ctrl_out_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    input  logic       is_bne_i,
    output ctrl_t      ctrl_o
);

    // Decode the control word for the current state; unlisted fields stay 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.adr_src    = ADR_PC;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                // IR and PC only capture once the fetched word is valid
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            S_DECODE: begin
                // Precompute OldPC + imm as the branch target
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_REGA;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.adr_src    = ADR_RESULT;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.mem_read   = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole access, including wait cycles
                ctrl_o.adr_src    = ADR_RESULT;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.mem_write  = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_MEMDATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = SRCA_REGA;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = SRCA_REGA;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_JAL: begin
                // PC <= branch target held in ALUOut, ALU forms OldPC + 4 for rd
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_REGA;
                ctrl_o.alu_src_b  = SRCB_REGB;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = branch_taken(zero_i, is_bne_i);
            end
            default: ctrl_o = '0;   // IDLE, TRAP and unused codes drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RISC-V datapath. Holds the state
// register, next-state logic and the sticky illegal-opcode flag; the
// output table lives in ctrl_out_decoder.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [6:0] i_Opcode,
    input  logic [2:0] i_Funct3,
    input  logic       i_Zero,
    input  logic       i_MemReady,
    output logic       o_PCWrite,
    output logic       o_AdrSrc,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp,
    output logic       o_Illegal
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal_q;
    ctrl_t      ctrl;

    // Only funct3[0] matters here (beq/bne); the rest belongs to the ALU decoder
    logic       funct3_unused;
    assign funct3_unused = ^i_Funct3[2:1];

    // Next-state selection; unknown opcodes fall into the default and trap
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = i_MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BRANCH:    state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // IR is frozen since FETCH, so the opcode still selects load/store
                case (i_Opcode)
                    OP_LW:   state_d = S_MEMREAD;
                    OP_SW:   state_d = S_MEMWRITE;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMREAD:  state_d = i_MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = i_MemReady ? S_FETCH : S_MEMWRITE;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // State register and sticky illegal flag; reset wins over everything
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    ctrl_out_decoder u_out_dec (
        .state_i     (state_q),
        .mem_ready_i (i_MemReady),
        .zero_i      (i_Zero),
        .is_bne_i    (i_Funct3[0]),
        .ctrl_o      (ctrl)
    );

    assign o_PCWrite   = ctrl.pc_write;
    assign o_AdrSrc    = ctrl.adr_src;
    assign o_MemRead   = ctrl.mem_read;
    assign o_MemWrite  = ctrl.mem_write;
    assign o_IRWrite   = ctrl.ir_write;
    assign o_RegWrite  = ctrl.reg_write;
    assign o_ResultSrc = ctrl.result_src;
    assign o_ALUSrcA   = ctrl.alu_src_a;
    assign o_ALUSrcB   = ctrl.alu_src_b;
    assign o_ALUOp     = ctrl.alu_op;
    assign o_Illegal   = illegal_q;

endmodule
